// File: rtl/spike_interval_monitor_if.sv
// Spike-stream and measurement-result bundle between the neuron core and the
// spike interval monitor.
interface spike_interval_monitor_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
);
  logic             ena;
  logic             spike_in;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] spike_count;
  logic [WIN_W-1:0] isi_min;
  logic [WIN_W-1:0] isi_last;
  logic             isi_valid;

  modport master (
    output ena, spike_in, start, window_len,
    input  busy, done, spike_count, isi_min, isi_last, isi_valid
  );

  modport slave (
    input  ena, spike_in, start, window_len,
    output busy, done, spike_count, isi_min, isi_last, isi_valid
  );
endinterface

// File: rtl/spike_interval_monitor.sv
// Counts spikes in a programmable window and tracks the minimum and most
// recent inter-spike interval; results hold until the next window completes.
//
// state | meaning
// IDLE  | waiting for start; results from the last window are held
// RUN   | window running; win_cnt counts down the remaining cycles
module spike_interval_monitor #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  spike_interval_monitor_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIN_W-1:0] WIN_ONES = '1;
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t           state;
  logic             busy;
  logic             done;
  logic             spike_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] isi_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [WIN_W-1:0] acc_min;
  logic [WIN_W-1:0] acc_last;
  logic             seen;
  logic [CNT_W-1:0] spike_count;
  logic [WIN_W-1:0] isi_min;
  logic [WIN_W-1:0] isi_last;
  logic             isi_valid;

  logic             spike_edge;
  logic             win_last;
  logic [WIN_W-1:0] isi_inc;
  logic [CNT_W-1:0] acc_cnt_nxt;
  logic [WIN_W-1:0] acc_min_nxt;
  logic [WIN_W-1:0] acc_last_nxt;

  // Next accumulator values include the current cycle's edge so the final
  // window cycle can be folded straight into the published results.
  always_comb begin
    spike_edge   = bus.spike_in & ~spike_prev;
    win_last     = (win_cnt == WIN_ONE);
    isi_inc      = (isi_cnt == WIN_ONES) ? WIN_ONES : isi_cnt + WIN_ONE;
    acc_cnt_nxt  = acc_cnt;
    acc_min_nxt  = acc_min;
    acc_last_nxt = acc_last;
    if (spike_edge) begin
      if (acc_cnt != CNT_ONES) begin
        acc_cnt_nxt = acc_cnt + CNT_W'(1);
      end
      if (seen) begin
        acc_last_nxt = isi_inc;
        if (isi_inc < acc_min) begin
          acc_min_nxt = isi_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_prev  <= 1'b0;
      win_cnt     <= '0;
      isi_cnt     <= '0;
      acc_cnt     <= '0;
      acc_min     <= WIN_ONES;
      acc_last    <= '0;
      seen        <= 1'b0;
      spike_count <= '0;
      isi_min     <= '0;
      isi_last    <= '0;
      isi_valid   <= 1'b0;
    end else begin
      // Edge history runs free so a level already high at start is not a spike.
      spike_prev <= bus.spike_in;
      if (bus.ena) begin
        done <= 1'b0;
        case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= RUN;
              busy     <= 1'b1;
              win_cnt  <= (bus.window_len == '0) ? WIN_ONE : bus.window_len;
              isi_cnt  <= '0;
              acc_cnt  <= '0;
              acc_min  <= WIN_ONES;
              acc_last <= '0;
              seen     <= 1'b0;
            end
          end
          RUN: begin
            win_cnt  <= win_cnt - WIN_ONE;
            isi_cnt  <= spike_edge ? '0 : isi_inc;
            acc_cnt  <= acc_cnt_nxt;
            acc_min  <= acc_min_nxt;
            acc_last <= acc_last_nxt;
            if (spike_edge) begin
              seen <= 1'b1;
            end
            if (win_last) begin
              state       <= IDLE;
              busy        <= 1'b0;
              done        <= 1'b1;
              spike_count <= acc_cnt_nxt;
              isi_min     <= acc_min_nxt;
              isi_last    <= acc_last_nxt;
              isi_valid   <= (acc_cnt_nxt >= CNT_TWO);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.spike_count = spike_count;
  assign bus.isi_min     = isi_min;
  assign bus.isi_last    = isi_last;
  assign bus.isi_valid   = isi_valid;

endmodule

// File: tb/tb_spike_interval_monitor.sv
// Directed bench for spike_interval_monitor: table of spike patterns with
// hand-computed results, plus sequences for reset, start and enable corners.
module tb_spike_interval_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  spike_interval_monitor_if #(.WIN_W(16), .CNT_W(8)) bus ();

  spike_interval_monitor #(.WIN_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int pre;
    int p0, p1, p2, p3;
    int first, period, width, npulse;
    int exp_cnt, exp_min, exp_last, exp_valid;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(int len, int pre, int p0, int p1, int p2, int p3,
                              int first, int period, int width, int npulse,
                              int ec, int emin, int elast, int ev);
    vec_t v;
    v.len = len; v.pre = pre;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.first = first; v.period = period; v.width = width; v.npulse = npulse;
    v.exp_cnt = ec; v.exp_min = emin; v.exp_last = elast; v.exp_valid = ev;
    return v;
  endfunction

  // Spike level in window cycle k (k = 0 is the cycle before start).
  function automatic bit spike_at(vec_t v, int k);
    if (v.pre > 0 && k <= v.pre) return 1'b1;
    if (k > 0 && (k == v.p0 || k == v.p1 || k == v.p2 || k == v.p3)) return 1'b1;
    if (v.npulse > 0 && k >= v.first && k < v.first + v.period * v.npulse &&
        ((k - v.first) % v.period) < v.width) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(string tag, int ec, int emin, int elast, int ev);
    check($sformatf("%s spike_count", tag), 32'(bus.spike_count), ec);
    check($sformatf("%s isi_min", tag), 32'(bus.isi_min), emin);
    check($sformatf("%s isi_last", tag), 32'(bus.isi_last), elast);
    check($sformatf("%s isi_valid", tag), 32'(bus.isi_valid), ev);
  endtask

  task automatic run_vec(int idx);
    vec_t v;
    int   n;
    bit   bad;
    string tag;
    v   = vecs[idx];
    n   = (v.len == 0) ? 1 : v.len;
    bad = 1'b0;
    tag = $sformatf("vec%0d", idx);
    bus.spike_in = spike_at(v, 0);
    tick();
    bus.start      = 1'b1;
    bus.window_len = 16'(v.len);
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      bus.spike_in = spike_at(v, k);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
      tick();
    end
    bus.spike_in = 1'b0;
    check($sformatf("%s busy_through_window", tag), 32'(bad), 0);
    check($sformatf("%s done", tag), 32'(bus.done), 1);
    check($sformatf("%s busy_at_done", tag), 32'(bus.busy), 0);
    check_results(tag, v.exp_cnt, v.exp_min, v.exp_last, v.exp_valid);
    tick();
    check($sformatf("%s done_pulse_width", tag), 32'(bus.done), 0);
  endtask

  initial begin
    bit bad;
    checks   = 0;
    failures = 0;

    //          len  pre p0 p1 p2 p3 first per w  n    cnt  min     last valid
    vecs[0] = mk(100, 0, 10, 30, 45, 0, 0,   1,  0, 0,   3,   15,     15,  1);
    vecs[1] = mk(100, 0, 5,  8,  20, 0, 0,   1,  0, 0,   3,   3,      12,  1);
    vecs[2] = mk(50,  0, 0,  0,  0,  0, 5,   50, 20, 1,  1,   'hFFFF, 0,   0);
    vecs[3] = mk(1000,0, 0,  0,  0,  0, 3,   3,  1, 333, 255, 3,      3,   1);
    vecs[4] = mk(20,  0, 0,  0,  0,  0, 2,   4,  2, 4,   4,   4,      4,   1);
    vecs[5] = mk(10,  0, 1,  10, 0,  0, 0,   1,  0, 0,   2,   9,      9,   1);
    vecs[6] = mk(0,   0, 0,  0,  0,  0, 0,   1,  0, 0,   0,   'hFFFF, 0,   0);
    vecs[7] = mk(1,   0, 1,  0,  0,  0, 0,   1,  0, 0,   1,   'hFFFF, 0,   0);
    vecs[8] = mk(12,  3, 6,  9,  0,  0, 0,   1,  0, 0,   2,   3,      3,   1);

    rst            = 1'b1;
    bus.ena        = 1'b1;
    bus.spike_in   = 1'b0;
    bus.start      = 1'b0;
    bus.window_len = '0;
    #1;
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check_results("reset", 0, 0, 0, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    check("post_reset busy", 32'(bus.busy), 0);

    for (int i = 0; i < 9; i++) begin
      run_vec(i);
    end

    // Asynchronous reset mid-cycle clears held results immediately.
    #3 rst = 1'b1;
    #1;
    check("async_rst busy", 32'(bus.busy), 0);
    check("async_rst done", 32'(bus.done), 0);
    check_results("async_rst", 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    check("async_rst release busy", 32'(bus.busy), 0);

    // Start during RUN and on the final cycle is ignored.
    bus.start      = 1'b1;
    bus.window_len = 16'd40;
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      bus.start = (k == 20 || k == 40);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    check("restart busy_through_window", 32'(bad), 0);
    check("restart done", 32'(bus.done), 1);
    check("restart busy_at_done", 32'(bus.busy), 0);
    check_results("restart", 0, 'hFFFF, 0, 0);
    tick();
    check("restart final_start_ignored", 32'(bus.busy), 0);

    // Enable low for 10 cycles: window stretches, the edge seen while frozen is lost.
    bus.start      = 1'b1;
    bus.window_len = 16'd30;
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      bus.ena      = !(t >= 11 && t <= 20);
      bus.spike_in = (t == 5 || t == 15 || t == 25);
      if (bus.done !== 1'b0) bad = 1'b1;
      tick();
    end
    bus.ena      = 1'b1;
    bus.spike_in = 1'b0;
    check("ena_gap no_early_done", 32'(bad), 0);
    check("ena_gap done", 32'(bus.done), 1);
    check_results("ena_gap", 2, 10, 10, 1);
    tick();

    // Reset in window cycle 25 discards the window and clears results.
    bus.start      = 1'b1;
    bus.window_len = 16'd100;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      bus.spike_in = (k == 5 || k == 10);
      tick();
    end
    bus.spike_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst busy", 32'(bus.busy), 0);
    check_results("mid_rst", 0, 0, 0, 0);
    #2 rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    check("mid_rst no_done", 32'(bad), 0);
    check("mid_rst spike_count_held", 32'(bus.spike_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
